pointwise_out_axis_serializer: RTL and testbench
================================================

// Module: pointwise_out_axis_serializer
// PURPOSE
// - Consumes one full pointwise-conv result vector (COUT x DATA_W, channel c at bits [c*DATA_W +: DATA_W]) over AXI-Stream.
// - Streams it out as BEAT_LANES-channel AXI-Stream beats toward the DMA/output buffer.
// - Marks the final beat with tlast and partial-beat lanes with tkeep; pulses o_intr once per frame.
// PARAMETERS
// - DATA_W      8   bits per channel element (saturated int8)
// - COUT        64  channels per result vector
// - BEAT_LANES  8   channels per output beat; NUM_BEATS = ceil(COUT/BEAT_LANES)
// - CNT_W       16  width of frame_cnt status counter
// PORTS
// - clk            in   1                  clock
// - reset_n        in   1                  asynchronous, active-low reset
// - s_axis_tvalid  in   1                  result vector valid
// - s_axis_tready  out  1                  result vector accepted when tvalid&tready
// - s_axis_tdata   in   COUT*DATA_W        result vector
// - m_axis_tvalid  out  1                  output beat valid
// - m_axis_tready  in   1                  downstream ready
// - m_axis_tdata   out  BEAT_LANES*DATA_W  channels k*BEAT_LANES+i at lane i
// - m_axis_tkeep   out  BEAT_LANES         1 per valid lane
// - m_axis_tlast   out  1                  final beat of frame
// - busy           out  1                  frame held (state SEND)
// - frame_cnt      out  CNT_W              frames fully sent, wraps at 2^CNT_W
// - o_intr         out  1                  1-cycle pulse, cycle after last beat handshake
// BEHAVIOUR
// - Reset (async assert, sync release): state=IDLE, beat_cnt=0, buffer=0, all outputs 0 (s_axis_tready is 1 after
//   reset since it decodes IDLE); reset mid-frame discards the frame, no tlast/o_intr issued.
// - States: IDLE -> SEND on s_axis_tvalid&tready (vector latched to buffer, beat_cnt=0).
//   SEND: beat k = beat_cnt presented; on m_axis_tvalid&m_axis_tready: if k<NUM_BEATS-1 beat_cnt++,
//   else frame complete -> IDLE, frame_cnt++, o_intr pulses next cycle.
// - s_axis_tready = (state==IDLE) | (state==SEND & last beat & m_axis_tready): back-to-back frames allowed;
//   simultaneous last-beat handshake and new accept -> stay SEND, reload buffer, beat_cnt=0, frame_cnt++, o_intr pulse.
// - m_axis_tvalid = (state==SEND); tdata/tkeep/tlast driven from registered buffer and beat_cnt; they are
//   stable while tvalid&!tready (AXI rule); tvalid never drops without a handshake.
// - Latency: first beat valid 1 cycle after input handshake; full frame >= NUM_BEATS cycles with tready=1.
// - tkeep: all 1s except last beat when COUT%BEAT_LANES!=0 -> low (COUT%BEAT_LANES) bits set; invalid lanes
//   of tdata are driven 0. tlast = (beat_cnt==NUM_BEATS-1); NUM_BEATS==1 -> tlast on every beat.
// - beat_cnt width max(1,$clog2(NUM_BEATS)); no wrap past NUM_BEATS-1.
// - s_axis_tvalid while SEND (not last beat) is ignored (tready=0); input must hold per AXI rules.
// - frame_cnt wraps silently from 2^CNT_W-1 to 0.
// STRUCTURE
// - Shared package cnn_accel_pkg: DATA_W default, state encoding (IDLE/SEND), helper function ceil_div,
//   tkeep-mask function last_keep(COUT,BEAT_LANES).
// - One sub-module natural: axis_beat_mux (buffer + beat_cnt -> tdata/tkeep lane select, zero-fill); FSM,
//   counters and handshake stay in top.
// TESTING
// - COUT=64,LANES=8, vector ch c = c, tready=1 -> 8 beats, beat k lane i = 8k+i, tlast only beat 7, tkeep=8'hFF,
//   o_intr one pulse, frame_cnt=1.
// - COUT=20,LANES=8 -> 3 beats; beat 2 tkeep=8'h0F, lanes 4..7 = 0, tlast on beat 2.
// - Random tready (50%) over 100 frames -> tdata/tkeep/tlast stable during stall, no lost/duplicated beats,
//   frame_cnt=100, exactly 100 o_intr pulses.
// - Back-to-back: s_axis_tvalid held high, tready=1 -> next frame accepted in last-beat cycle, zero-bubble
//   output (16 consecutive beats for 2 frames of COUT=64).
// - Assert reset_n=0 mid-frame at beat 3 -> outputs 0 asynchronously, IDLE after release, no o_intr,
//   frame_cnt unchanged from before frame.
// - COUT=8,LANES=8 (NUM_BEATS=1) -> single beat with tlast=1, tkeep=8'hFF; CNT_W=2, 5 frames -> frame_cnt=1.

Source files
------------

// File: rtl/pointwise_out_axis_serializer_pkg.sv
// Shared accelerator package: default widths, serializer state encoding,
// and constant helpers for beat count and partial-beat keep mask.
package cnn_accel_pkg;

    localparam int DEF_DATA_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    // Low (cout % lanes) bits set; a full beat when cout divides evenly.
    function automatic logic [63:0] last_keep(input int cout, input int lanes);
        int r;
        r = cout % lanes;
        if (r == 0) r = lanes;
        return (64'(1) << r) - 64'(1);
    endfunction

endpackage

// File: rtl/pointwise_out_axis_serializer_if.sv
// AXI-Stream bundles: wide result-vector input and keep/last output beats.
// Producer side drives master, consumer side uses slave.
interface pointwise_out_axis_serializer_if #(
    parameter int DATA_BITS = 512
);
    logic                 tvalid;
    logic                 tready;
    logic [DATA_BITS-1:0] tdata;

    modport master (output tvalid, output tdata, input tready);
    modport slave  (input tvalid, input tdata, output tready);
endinterface

interface pointwise_out_axis_serializer_m_if #(
    parameter int DATA_BITS = 64,
    parameter int KEEP_BITS = 8
);
    logic                 tvalid;
    logic                 tready;
    logic [DATA_BITS-1:0] tdata;
    logic [KEEP_BITS-1:0] tkeep;
    logic                 tlast;

    modport master (output tvalid, output tdata, output tkeep,
                    output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tkeep,
                    input tlast, output tready);
endinterface

// File: rtl/pointwise_out_axis_serializer_axis_beat_mux.sv
// Selects one beat of lanes from the held result vector, zero-filling
// lanes past COUT, and derives tkeep/tlast for that beat.
module axis_beat_mux
    import cnn_accel_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int COUT       = 64,
    parameter int BEAT_LANES = 8,
    parameter int NUM_BEATS  = ceil_div(COUT, BEAT_LANES),
    parameter int BW         = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1
) (
    input  logic                         valid,
    input  logic [COUT*DATA_W-1:0]       buffer,
    input  logic [BW-1:0]                beat_cnt,
    output logic [BEAT_LANES*DATA_W-1:0] tdata,
    output logic [BEAT_LANES-1:0]        tkeep,
    output logic                         tlast
);
    localparam int BEAT_W = BEAT_LANES * DATA_W;
    localparam int DEPTH  = 2 ** BW;
    localparam int PAD_W  = DEPTH * BEAT_W;
    localparam logic [BW-1:0] LAST = BW'(NUM_BEATS - 1);
    localparam logic [BEAT_LANES-1:0] LAST_KEEP =
        BEAT_LANES'(last_keep(COUT, BEAT_LANES));

    logic [DEPTH-1:0][BEAT_W-1:0] padded;
    logic                         is_last;

    assign padded  = PAD_W'(buffer);
    assign is_last = (beat_cnt == LAST);

    // Outputs read zero whenever no beat is being presented.
    always_comb begin
        tdata = '0;
        tkeep = '0;
        tlast = 1'b0;
        if (valid) begin
            tdata = padded[beat_cnt];
            tkeep = is_last ? LAST_KEEP : '1;
            tlast = is_last;
        end
    end

endmodule

// File: rtl/pointwise_out_axis_serializer.sv
// Holds one pointwise-conv result vector and streams it out as
// BEAT_LANES-wide AXI-Stream beats with tkeep/tlast and a frame interrupt.
module pointwise_out_axis_serializer
    import cnn_accel_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int COUT       = 64,
    parameter int BEAT_LANES = 8,
    parameter int CNT_W      = 16
) (
    input  logic                             clk,
    input  logic                             reset_n,
    pointwise_out_axis_serializer_if.slave   s_axis,
    pointwise_out_axis_serializer_m_if.master m_axis,
    output logic                             busy,
    output logic [CNT_W-1:0]                 frame_cnt,
    output logic                             o_intr
);
    localparam int NUM_BEATS = ceil_div(COUT, BEAT_LANES);
    localparam int BW = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam logic [BW-1:0] LAST = BW'(NUM_BEATS - 1);

    state_t                 state, state_n;
    logic [BW-1:0]          beat_cnt, beat_cnt_n;
    logic [COUT*DATA_W-1:0] buffer;
    logic                   m_hs, done, accept;

    assign busy          = (state == SEND);
    assign m_axis.tvalid = busy;
    assign m_hs          = busy & m_axis.tready;
    assign done          = m_hs & (beat_cnt == LAST);
    assign s_axis.tready = (state == IDLE) | done;
    assign accept        = s_axis.tvalid & s_axis.tready;

    // Next state and beat index; a new vector may load on the last beat.
    always_comb begin
        state_n    = state;
        beat_cnt_n = beat_cnt;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_n    = SEND;
                    beat_cnt_n = '0;
                end
            end
            SEND: begin
                if (done) begin
                    state_n    = accept ? SEND : IDLE;
                    beat_cnt_n = '0;
                end else if (m_hs) begin
                    beat_cnt_n = beat_cnt + BW'(1);
                end
            end
            default: begin
                state_n    = IDLE;
                beat_cnt_n = '0;
            end
        endcase
    end

    // State and beat counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            beat_cnt <= '0;
        end else begin
            state    <= state_n;
            beat_cnt <= beat_cnt_n;
        end
    end

    // Vector capture, completed-frame counter and one-cycle interrupt.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            buffer    <= '0;
            frame_cnt <= '0;
            o_intr    <= 1'b0;
        end else begin
            if (accept) buffer <= s_axis.tdata;
            if (done) frame_cnt <= frame_cnt + CNT_W'(1);
            o_intr <= done;
        end
    end

    axis_beat_mux #(
        .DATA_W     (DATA_W),
        .COUT       (COUT),
        .BEAT_LANES (BEAT_LANES)
    ) u_mux (
        .valid    (busy),
        .buffer   (buffer),
        .beat_cnt (beat_cnt),
        .tdata    (m_axis.tdata),
        .tkeep    (m_axis.tkeep),
        .tlast    (m_axis.tlast)
    );

endmodule

// File: tb/tb_pointwise_out_axis_serializer.sv
// Directed bench for the result-vector serializer: three configurations
// (COUT 64, 20 and 8 with a 2-bit frame counter) driven from one sequence.
module tb_pointwise_out_axis_serializer;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int ic64 = 0;
    int ic8 = 0;
    int exp_fc64 = 0;

    pointwise_out_axis_serializer_if   #(.DATA_BITS(512)) s64 ();
    pointwise_out_axis_serializer_m_if #(.DATA_BITS(64), .KEEP_BITS(8)) m64 ();
    pointwise_out_axis_serializer_if   #(.DATA_BITS(160)) s20 ();
    pointwise_out_axis_serializer_m_if #(.DATA_BITS(64), .KEEP_BITS(8)) m20 ();
    pointwise_out_axis_serializer_if   #(.DATA_BITS(64)) s8 ();
    pointwise_out_axis_serializer_m_if #(.DATA_BITS(64), .KEEP_BITS(8)) m8 ();

    logic        busy64, busy20, busy8;
    logic [15:0] fc64, fc20;
    logic [1:0]  fc8;
    logic        intr64, intr20, intr8;

    pointwise_out_axis_serializer #(.COUT(64)) u64 (
        .clk(clk), .reset_n(reset_n), .s_axis(s64), .m_axis(m64),
        .busy(busy64), .frame_cnt(fc64), .o_intr(intr64));

    pointwise_out_axis_serializer #(.COUT(20)) u20 (
        .clk(clk), .reset_n(reset_n), .s_axis(s20), .m_axis(m20),
        .busy(busy20), .frame_cnt(fc20), .o_intr(intr20));

    pointwise_out_axis_serializer #(.COUT(8), .CNT_W(2)) u8 (
        .clk(clk), .reset_n(reset_n), .s_axis(s8), .m_axis(m8),
        .busy(busy8), .frame_cnt(fc8), .o_intr(intr8));

    always @(posedge clk) begin
        if (intr64) ic64++;
        if (intr8) ic8++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] v64(input int f, input int c);
        return 8'(f * 7 + c);
    endfunction

    function automatic logic [63:0] exp64(input int f, input int k);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[i*8 +: 8] = v64(f, 8 * k + i);
        return r;
    endfunction

    function automatic logic [63:0] exp20(input int k);
        logic [63:0] r;
        int ch;
        for (int i = 0; i < 8; i++) begin
            ch = 8 * k + i;
            r[i*8 +: 8] = (ch < 20) ? 8'(ch + 1) : 8'h00;
        end
        return r;
    endfunction

    task automatic load64(input int f);
        for (int c = 0; c < 64; c++) s64.tdata[c*8 +: 8] = v64(f, c);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step();
        step();
        checks++; if (m64.tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %0b want 0", m64.tvalid); end
        checks++; if (m64.tdata !== 64'h0) begin errors++; $display("FAIL reset_tdata got %h want 0", m64.tdata); end
        checks++; if (m64.tkeep !== 8'h00) begin errors++; $display("FAIL reset_tkeep got %h want 00", m64.tkeep); end
        checks++; if (m64.tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast got %0b want 0", m64.tlast); end
        checks++; if (m8.tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast_1beat got %0b want 0", m8.tlast); end
        checks++; if (busy64 !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy64); end
        checks++; if (fc64 !== 16'd0) begin errors++; $display("FAIL reset_frame_cnt got %0d want 0", fc64); end
        checks++; if (intr64 !== 1'b0) begin errors++; $display("FAIL reset_intr got %0b want 0", intr64); end
        reset_n = 1'b1;
        step();
        checks++; if (s64.tready !== 1'b1) begin errors++; $display("FAIL reset_s_tready got %0b want 1", s64.tready); end
    endtask

    task automatic test_reset_mid();
        load64(0);
        s64.tvalid = 1'b1;
        m64.tready = 1'b1;
        step();
        s64.tvalid = 1'b0;
        for (int k = 0; k < 3; k++) step();
        checks++; if (m64.tdata !== exp64(0, 3)) begin errors++; $display("FAIL mid_beat3 got %h want %h", m64.tdata, exp64(0, 3)); end
        reset_n = 1'b0;
        #1;
        checks++; if (m64.tvalid !== 1'b0) begin errors++; $display("FAIL mid_async_tvalid got %0b want 0", m64.tvalid); end
        checks++; if (m64.tdata !== 64'h0) begin errors++; $display("FAIL mid_async_tdata got %h want 0", m64.tdata); end
        checks++; if (m64.tkeep !== 8'h00) begin errors++; $display("FAIL mid_async_tkeep got %h want 00", m64.tkeep); end
        checks++; if (m64.tlast !== 1'b0) begin errors++; $display("FAIL mid_async_tlast got %0b want 0", m64.tlast); end
        checks++; if (busy64 !== 1'b0) begin errors++; $display("FAIL mid_async_busy got %0b want 0", busy64); end
        step();
        reset_n = 1'b1;
        step();
        step();
        checks++; if (busy64 !== 1'b0) begin errors++; $display("FAIL mid_idle_busy got %0b want 0", busy64); end
        checks++; if (s64.tready !== 1'b1) begin errors++; $display("FAIL mid_idle_tready got %0b want 1", s64.tready); end
        checks++; if (fc64 !== 16'd0) begin errors++; $display("FAIL mid_frame_cnt got %0d want 0", fc64); end
        checks++; if (ic64 !== 0) begin errors++; $display("FAIL mid_no_intr got %0d want 0", ic64); end
    endtask

    task automatic test_full64();
        int ic0;
        ic0 = ic64;
        load64(0);
        s64.tvalid = 1'b1;
        m64.tready = 1'b1;
        step();
        s64.tvalid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            checks++; if (m64.tvalid !== 1'b1) begin errors++; $display("FAIL full_tvalid beat %0d got %0b want 1", k, m64.tvalid); end
            checks++; if (m64.tdata !== exp64(0, k)) begin errors++; $display("FAIL full_tdata beat %0d got %h want %h", k, m64.tdata, exp64(0, k)); end
            checks++; if (m64.tkeep !== 8'hFF) begin errors++; $display("FAIL full_tkeep beat %0d got %h want FF", k, m64.tkeep); end
            checks++; if (m64.tlast !== (k == 7)) begin errors++; $display("FAIL full_tlast beat %0d got %0b want %0b", k, m64.tlast, (k == 7)); end
            step();
        end
        exp_fc64++;
        checks++; if (busy64 !== 1'b0) begin errors++; $display("FAIL full_idle got %0b want 0", busy64); end
        checks++; if (intr64 !== 1'b1) begin errors++; $display("FAIL full_intr got %0b want 1", intr64); end
        checks++; if (fc64 !== 16'(exp_fc64)) begin errors++; $display("FAIL full_frame_cnt got %0d want %0d", fc64, exp_fc64); end
        step();
        checks++; if (intr64 !== 1'b0) begin errors++; $display("FAIL full_intr_pulse got %0b want 0", intr64); end
        checks++; if (ic64 - ic0 !== 1) begin errors++; $display("FAIL full_intr_count got %0d want 1", ic64 - ic0); end
    endtask

    task automatic test_cout20();
        for (int c = 0; c < 20; c++) s20.tdata[c*8 +: 8] = 8'(c + 1);
        s20.tvalid = 1'b1;
        m20.tready = 1'b1;
        step();
        s20.tvalid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++; if (m20.tdata !== exp20(k)) begin errors++; $display("FAIL c20_tdata beat %0d got %h want %h", k, m20.tdata, exp20(k)); end
            checks++; if (m20.tkeep !== ((k == 2) ? 8'h0F : 8'hFF)) begin errors++; $display("FAIL c20_tkeep beat %0d got %h", k, m20.tkeep); end
            checks++; if (m20.tlast !== (k == 2)) begin errors++; $display("FAIL c20_tlast beat %0d got %0b want %0b", k, m20.tlast, (k == 2)); end
            step();
        end
        checks++; if (busy20 !== 1'b0) begin errors++; $display("FAIL c20_idle got %0b want 0", busy20); end
        checks++; if (fc20 !== 16'd1) begin errors++; $display("FAIL c20_frame_cnt got %0d want 1", fc20); end
    endtask

    task automatic test_random_stall();
        int ic0, k, cyc;
        logic hs, prev_stall;
        logic [63:0] prev_data;
        logic [7:0] prev_keep;
        logic prev_last;
        ic0 = ic64;
        for (int f = 1; f <= 100; f++) begin
            load64(f);
            s64.tvalid = 1'b1;
            step();
            s64.tvalid = 1'b0;
            k = 0;
            cyc = 0;
            prev_stall = 1'b0;
            prev_data = '0;
            prev_keep = '0;
            prev_last = 1'b0;
            while (k < 8 && cyc < 200) begin
                m64.tready = 1'($urandom % 2);
                checks++; if (m64.tvalid !== 1'b1) begin errors++; $display("FAIL rnd_tvalid f %0d beat %0d got %0b", f, k, m64.tvalid); end
                checks++; if (m64.tdata !== exp64(f, k)) begin errors++; $display("FAIL rnd_tdata f %0d beat %0d got %h want %h", f, k, m64.tdata, exp64(f, k)); end
                checks++; if (m64.tlast !== (k == 7)) begin errors++; $display("FAIL rnd_tlast f %0d beat %0d got %0b", f, k, m64.tlast); end
                if (prev_stall) begin
                    checks++;
                    if (m64.tdata !== prev_data || m64.tkeep !== prev_keep || m64.tlast !== prev_last) begin
                        errors++;
                        $display("FAIL rnd_stable f %0d beat %0d got %h/%h want %h/%h", f, k, m64.tdata, m64.tkeep, prev_data, prev_keep);
                    end
                end
                hs = m64.tready;
                prev_data = m64.tdata;
                prev_keep = m64.tkeep;
                prev_last = m64.tlast;
                prev_stall = !hs;
                step();
                if (hs) k++;
                cyc++;
            end
            checks++; if (k != 8) begin errors++; $display("FAIL rnd_timeout f %0d beats %0d want 8", f, k); end
            exp_fc64++;
        end
        m64.tready = 1'b1;
        step();
        step();
        checks++; if (fc64 !== 16'(exp_fc64)) begin errors++; $display("FAIL rnd_frame_cnt got %0d want %0d", fc64, exp_fc64); end
        checks++; if (ic64 - ic0 !== 100) begin errors++; $display("FAIL rnd_intr_count got %0d want 100", ic64 - ic0); end
    endtask

    task automatic test_back_to_back();
        int ic0;
        ic0 = ic64;
        load64(200);
        s64.tvalid = 1'b1;
        m64.tready = 1'b1;
        step();
        load64(201);
        for (int j = 0; j < 16; j++) begin
            if (j == 8) begin
                s64.tvalid = 1'b0;
                checks++; if (intr64 !== 1'b1) begin errors++; $display("FAIL b2b_intr_mid got %0b want 1", intr64); end
            end
            checks++; if (m64.tvalid !== 1'b1) begin errors++; $display("FAIL b2b_bubble beat %0d got %0b want 1", j, m64.tvalid); end
            checks++; if (m64.tdata !== exp64(200 + j / 8, j % 8)) begin errors++; $display("FAIL b2b_tdata beat %0d got %h want %h", j, m64.tdata, exp64(200 + j / 8, j % 8)); end
            if (j == 3) begin
                checks++; if (s64.tready !== 1'b0) begin errors++; $display("FAIL b2b_tready_mid got %0b want 0", s64.tready); end
            end
            if (j == 7) begin
                checks++; if (s64.tready !== 1'b1) begin errors++; $display("FAIL b2b_tready_last got %0b want 1", s64.tready); end
            end
            step();
        end
        exp_fc64 += 2;
        checks++; if (busy64 !== 1'b0) begin errors++; $display("FAIL b2b_idle got %0b want 0", busy64); end
        checks++; if (fc64 !== 16'(exp_fc64)) begin errors++; $display("FAIL b2b_frame_cnt got %0d want %0d", fc64, exp_fc64); end
        step();
        checks++; if (ic64 - ic0 !== 2) begin errors++; $display("FAIL b2b_intr_count got %0d want 2", ic64 - ic0); end
    endtask

    task automatic test_single_beat();
        logic [63:0] want;
        int ic0;
        ic0 = ic8;
        m8.tready = 1'b1;
        for (int f = 0; f < 5; f++) begin
            for (int i = 0; i < 8; i++) want[i*8 +: 8] = 8'(f * 8 + i + 1);
            s8.tdata = want;
            s8.tvalid = 1'b1;
            step();
            s8.tvalid = 1'b0;
            checks++; if (m8.tvalid !== 1'b1) begin errors++; $display("FAIL one_tvalid f %0d got %0b want 1", f, m8.tvalid); end
            checks++; if (m8.tlast !== 1'b1) begin errors++; $display("FAIL one_tlast f %0d got %0b want 1", f, m8.tlast); end
            checks++; if (m8.tkeep !== 8'hFF) begin errors++; $display("FAIL one_tkeep f %0d got %h want FF", f, m8.tkeep); end
            checks++; if (m8.tdata !== want) begin errors++; $display("FAIL one_tdata f %0d got %h want %h", f, m8.tdata, want); end
            step();
            checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL one_idle f %0d got %0b want 0", f, busy8); end
        end
        step();
        checks++; if (fc8 !== 2'd1) begin errors++; $display("FAIL one_frame_wrap got %0d want 1", fc8); end
        checks++; if (ic8 - ic0 !== 5) begin errors++; $display("FAIL one_intr_count got %0d want 5", ic8 - ic0); end
    endtask

    initial begin
        s64.tvalid = 1'b0; s64.tdata = '0; m64.tready = 1'b0;
        s20.tvalid = 1'b0; s20.tdata = '0; m20.tready = 1'b1;
        s8.tvalid = 1'b0;  s8.tdata = '0;  m8.tready = 1'b1;
        test_reset();
        test_reset_mid();
        test_full64();
        test_cout20();
        test_random_stall();
        test_back_to_back();
        test_single_beat();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
